// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: scans the voice table once per note event,
// then issues a start/stop command (free voice first, oldest voice stolen).
module voice_allocator #(
  parameter int NUM_VOICES = 8,
  parameter int TUNING_W   = 32,
  parameter int AGE_W      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_note_valid,
  output logic                  o_note_ready,
  input  logic                  i_note_on,
  input  logic [6:0]            i_note_num,
  input  logic [6:0]            i_velocity,
  input  logic [TUNING_W-1:0]   i_tuning_code,
  output logic                  o_voice_flag,
  output logic [7:0]            o_voice_index,
  output logic                  o_voice_note_status,
  output logic [TUNING_W-1:0]   o_voice_tuning_code,
  output logic [6:0]            o_voice_velocity,
  output logic                  o_steal,
  output logic [NUM_VOICES-1:0] o_active_mask
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_ISSUE} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_RETRIG, OP_ALLOC, OP_OFF} op_t;

  state_t state_q, state_d;
  op_t    op_q, op_d;

  logic                ev_on_q, ev_on_d;
  logic [6:0]          ev_note_q, ev_note_d;
  logic [6:0]          ev_vel_q, ev_vel_d;
  logic [TUNING_W-1:0] ev_tune_q, ev_tune_d;

  logic [IW-1:0]    scan_idx_q, scan_idx_d;
  logic             has_free_q, has_free_d;
  logic [IW-1:0]    free_idx_q, free_idx_d;
  logic             has_match_q, has_match_d;
  logic [IW-1:0]    match_idx_q, match_idx_d;
  logic             has_old_q, has_old_d;
  logic [IW-1:0]    old_idx_q, old_idx_d;
  logic [AGE_W-1:0] old_age_q, old_age_d;
  logic [IW-1:0]    tgt_q, tgt_d;

  logic                flag_q, flag_d;
  logic                steal_q, steal_d;
  logic [7:0]          vidx_q, vidx_d;
  logic                vstat_q, vstat_d;
  logic [TUNING_W-1:0] vtune_q, vtune_d;
  logic [6:0]          vvel_q, vvel_d;

  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [6:0]            note_q [NUM_VOICES];
  logic [6:0]            note_d [NUM_VOICES];
  logic [AGE_W-1:0]      age_q [NUM_VOICES];
  logic [AGE_W-1:0]      age_d [NUM_VOICES];

  logic scan_last;
  logic cur_act;

  assign scan_last = (scan_idx_q == LAST_IDX);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_note_valid) state_d = S_SCAN;
      S_SCAN:  if (scan_last) state_d = S_ISSUE;
      S_ISSUE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_note_ready = (state_q == S_IDLE);
  end

  always_comb begin
    ev_on_d     = ev_on_q;
    ev_note_d   = ev_note_q;
    ev_vel_d    = ev_vel_q;
    ev_tune_d   = ev_tune_q;
    scan_idx_d  = scan_idx_q;
    has_free_d  = has_free_q;
    free_idx_d  = free_idx_q;
    has_match_d = has_match_q;
    match_idx_d = match_idx_q;
    has_old_d   = has_old_q;
    old_idx_d   = old_idx_q;
    old_age_d   = old_age_q;
    op_d        = op_q;
    tgt_d       = tgt_q;
    flag_d      = 1'b0;
    steal_d     = 1'b0;
    vidx_d      = vidx_q;
    vstat_d     = vstat_q;
    vtune_d     = vtune_q;
    vvel_d      = vvel_q;
    active_d    = active_q;
    note_d      = note_q;
    age_d       = age_q;
    cur_act     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_note_valid) begin
          ev_on_d     = i_note_on;
          ev_note_d   = i_note_num;
          ev_vel_d    = i_velocity;
          ev_tune_d   = i_tuning_code;
          scan_idx_d  = '0;
          has_free_d  = 1'b0;
          has_match_d = 1'b0;
          has_old_d   = 1'b0;
        end
      end
      S_SCAN: begin
        cur_act = active_q[scan_idx_q];
        if (!cur_act && !has_free_q) begin
          has_free_d = 1'b1;
          free_idx_d = scan_idx_q;
        end
        if (cur_act && !has_match_q &&
            note_q[scan_idx_q] == ev_note_q) begin
          has_match_d = 1'b1;
          match_idx_d = scan_idx_q;
        end
        // Strict compare keeps the lowest index on equal ages.
        if (cur_act && (!has_old_q ||
            age_q[scan_idx_q] > old_age_q)) begin
          has_old_d = 1'b1;
          old_idx_d = scan_idx_q;
          old_age_d = age_q[scan_idx_q];
        end
        scan_idx_d = scan_idx_q + IW'(1);
        if (scan_last) begin
          op_d = OP_NONE;
          if (ev_on_q && ev_vel_q != '0) begin
            flag_d  = 1'b1;
            vstat_d = 1'b1;
            if (has_match_d) begin
              op_d  = OP_RETRIG;
              tgt_d = match_idx_d;
            end else if (has_free_d) begin
              op_d  = OP_ALLOC;
              tgt_d = free_idx_d;
            end else begin
              op_d    = OP_ALLOC;
              tgt_d   = old_idx_d;
              steal_d = 1'b1;
            end
          end else if (has_match_d) begin
            op_d    = OP_OFF;
            tgt_d   = match_idx_d;
            flag_d  = 1'b1;
            vstat_d = 1'b0;
          end
          if (flag_d) begin
            vidx_d = '0;
            vidx_d[IW-1:0] = tgt_d;
            vtune_d = ev_tune_q;
            vvel_d  = ev_vel_q;
          end
        end
      end
      S_ISSUE: begin
        case (op_q)
          OP_RETRIG: age_d[tgt_q] = '0;
          OP_ALLOC: begin
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (active_q[v] && IW'(v) != tgt_q &&
                  age_q[v] != AGE_MAX) begin
                age_d[v] = age_q[v] + AGE_W'(1);
              end
            end
            active_d[tgt_q] = 1'b1;
            note_d[tgt_q]   = ev_note_q;
            age_d[tgt_q]    = '0;
          end
          OP_OFF: begin
            active_d[tgt_q] = 1'b0;
            age_d[tgt_q]    = '0;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ev_on_q     <= 1'b0;
      ev_note_q   <= '0;
      ev_vel_q    <= '0;
      ev_tune_q   <= '0;
      scan_idx_q  <= '0;
      has_free_q  <= 1'b0;
      free_idx_q  <= '0;
      has_match_q <= 1'b0;
      match_idx_q <= '0;
      has_old_q   <= 1'b0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
      op_q        <= OP_NONE;
      tgt_q       <= '0;
      flag_q      <= 1'b0;
      steal_q     <= 1'b0;
      vidx_q      <= '0;
      vstat_q     <= 1'b0;
      vtune_q     <= '0;
      vvel_q      <= '0;
      active_q    <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note_q[v] <= '0;
        age_q[v]  <= '0;
      end
    end else begin
      ev_on_q     <= ev_on_d;
      ev_note_q   <= ev_note_d;
      ev_vel_q    <= ev_vel_d;
      ev_tune_q   <= ev_tune_d;
      scan_idx_q  <= scan_idx_d;
      has_free_q  <= has_free_d;
      free_idx_q  <= free_idx_d;
      has_match_q <= has_match_d;
      match_idx_q <= match_idx_d;
      has_old_q   <= has_old_d;
      old_idx_q   <= old_idx_d;
      old_age_q   <= old_age_d;
      op_q        <= op_d;
      tgt_q       <= tgt_d;
      flag_q      <= flag_d;
      steal_q     <= steal_d;
      vidx_q      <= vidx_d;
      vstat_q     <= vstat_d;
      vtune_q     <= vtune_d;
      vvel_q      <= vvel_d;
      active_q    <= active_d;
      note_q      <= note_d;
      age_q       <= age_d;
    end
  end

  assign o_voice_flag        = flag_q;
  assign o_steal             = steal_q;
  assign o_voice_index       = vidx_q;
  assign o_voice_note_status = vstat_q;
  assign o_voice_tuning_code = vtune_q;
  assign o_voice_velocity    = vvel_q;
  assign o_active_mask       = active_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed vector table,
// hand-written timing sequences and randomized events vs a table model.
module tb_voice_allocator;

  localparam int N = 8;
  localparam int TW = 32;

  logic          clk;
  logic          i_reset;
  logic          i_note_valid;
  logic          o_note_ready;
  logic          i_note_on;
  logic [6:0]    i_note_num;
  logic [6:0]    i_velocity;
  logic [TW-1:0] i_tuning_code;
  logic          o_voice_flag;
  logic [7:0]    o_voice_index;
  logic          o_voice_note_status;
  logic [TW-1:0] o_voice_tuning_code;
  logic [6:0]    o_voice_velocity;
  logic          o_steal;
  logic [N-1:0]  o_active_mask;

  voice_allocator #(.NUM_VOICES(N), .TUNING_W(TW), .AGE_W(4)) dut (
    .i_clk               (clk),
    .i_reset             (i_reset),
    .i_note_valid        (i_note_valid),
    .o_note_ready        (o_note_ready),
    .i_note_on           (i_note_on),
    .i_note_num          (i_note_num),
    .i_velocity          (i_velocity),
    .i_tuning_code       (i_tuning_code),
    .o_voice_flag        (o_voice_flag),
    .o_voice_index       (o_voice_index),
    .o_voice_note_status (o_voice_note_status),
    .o_voice_tuning_code (o_voice_tuning_code),
    .o_voice_velocity    (o_voice_velocity),
    .o_steal             (o_steal),
    .o_active_mask       (o_active_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: voice table kept as plain integer arrays.
  int m_act [N];
  int m_note [N];
  int m_age [N];
  logic [TW-1:0] last_tune;
  logic [7:0]    last_idx;

  task automatic model_reset();
    for (int v = 0; v < N; v++) begin
      m_act[v] = 0; m_note[v] = 0; m_age[v] = 0;
    end
    last_tune = '0;
    last_idx = '0;
  endtask

  function automatic logic [N-1:0] model_mask();
    logic [N-1:0] m;
    m = '0;
    for (int v = 0; v < N; v++) m[v] = (m_act[v] != 0);
    return m;
  endfunction

  task automatic model_event(input logic on, input int note, input int vel,
                             output logic flag, output int idx,
                             output logic stat, output logic steal);
    int match, free, old;
    match = -1; free = -1; old = -1;
    for (int v = 0; v < N; v++) begin
      if (m_act[v] != 0 && m_note[v] == note && match < 0) match = v;
      if (m_act[v] == 0 && free < 0) free = v;
      if (m_act[v] != 0 && (old < 0 || m_age[v] > m_age[old])) old = v;
    end
    flag = 0; idx = 0; stat = 0; steal = 0;
    if (on && vel != 0) begin
      flag = 1; stat = 1;
      if (match >= 0) begin
        idx = match;
        m_age[match] = 0;
      end else begin
        idx = (free >= 0) ? free : old;
        steal = (free < 0);
        for (int v = 0; v < N; v++)
          if (m_act[v] != 0 && v != idx && m_age[v] < 15) m_age[v]++;
        m_act[idx] = 1; m_note[idx] = note; m_age[idx] = 0;
      end
    end else if (match >= 0) begin
      flag = 1; idx = match;
      m_act[match] = 0; m_age[match] = 0;
    end
  endtask

  typedef struct {
    int         nflag;
    int         flag_off;
    int         nsteal;
    logic       steal_at_flag;
    int         rdy_low;
    int         rdy_hi_at;
    logic [7:0] idx;
    logic       stat;
    logic [TW-1:0] tune;
    logic [6:0] vel;
    logic [N-1:0] mask;
    logic [TW-1:0] tune_end;
  } obs_t;

  task automatic run_event(input logic on, input logic [6:0] n,
                           input logic [6:0] v, input logic [TW-1:0] t,
                           output obs_t o);
    int w;
    o.nflag = 0; o.flag_off = -1; o.nsteal = 0; o.steal_at_flag = 0;
    o.rdy_low = 0; o.rdy_hi_at = -1; o.idx = '0; o.stat = 0;
    o.tune = '0; o.vel = '0; o.mask = '0; o.tune_end = '0;
    i_note_on = on; i_note_num = n; i_velocity = v; i_tuning_code = t;
    i_note_valid = 1'b1;
    w = 0;
    while (w < 200) begin
      @(negedge clk);
      if (o_note_ready) break;
      w++;
    end
    if (w >= 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1");
      i_note_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 i_note_valid = 1'b0;
    for (int e = 0; e <= N + 2; e++) begin
      if (e > 0) begin
        @(posedge clk);
        #1;
      end
      if (o_voice_flag) begin
        o.nflag++; o.flag_off = e; o.idx = o_voice_index;
        o.stat = o_voice_note_status; o.tune = o_voice_tuning_code;
        o.vel = o_voice_velocity; o.steal_at_flag = o_steal;
      end
      if (o_steal) o.nsteal++;
      if (!o_note_ready) o.rdy_low++;
      else if (o.rdy_hi_at < 0) o.rdy_hi_at = e;
      if (e == N + 1) o.mask = o_active_mask;
    end
    o.tune_end = o_voice_tuning_code;
  endtask

  task automatic compare(input string tg, input obs_t o, input logic ef,
                         input int ei, input logic es, input logic est,
                         input logic [TW-1:0] et, input logic [6:0] ev,
                         input logic [N-1:0] em);
    chk({tg, ".nflag"}, o.nflag, ef ? 1 : 0);
    chk({tg, ".nsteal"}, o.nsteal, (ef && est) ? 1 : 0);
    chk({tg, ".rdy_low"}, o.rdy_low, N + 1);
    chk({tg, ".rdy_hi_at"}, o.rdy_hi_at, N + 1);
    chk({tg, ".mask"}, o.mask, em);
    if (ef) begin
      chk({tg, ".flag_off"}, o.flag_off, N);
      chk({tg, ".idx"}, o.idx, ei);
      chk({tg, ".stat"}, o.stat, es);
      chk({tg, ".tune"}, o.tune, et);
      chk({tg, ".vel"}, o.vel, ev);
      chk({tg, ".steal"}, o.steal_at_flag, est);
      last_tune = et;
      last_idx = 8'(ei);
    end else begin
      chk({tg, ".hold_tune"}, o.tune_end, last_tune);
      chk({tg, ".hold_idx"}, o_voice_index, last_idx);
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 i_reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic          rst;
    logic          on;
    logic [6:0]    note;
    logic [6:0]    vel;
    logic [TW-1:0] tune;
    logic          ef;
    int            ei;
    logic          es;
    logic          est;
    logic [N-1:0]  em;
  } vec_t;

  vec_t vecs [$];

  initial begin
    obs_t o;
    logic mf, ms, mst;
    int mi;
    logic [6:0] rn, rv;
    logic [TW-1:0] rt;
    logic ron;
    int f1, f2, acc2;
    logic [TW-1:0] tune2;
    logic [7:0] idx2;

    vecs.push_back('{1, 1, 60, 100, 20000000, 1, 0, 1, 0, 8'h01});
    for (int i = 1; i < 8; i++)
      vecs.push_back('{0, 1, 7'(60 + i), 7'(40 + i), 32'(1000 + i),
                       1, i, 1, 0, 8'((1 << (i + 1)) - 1)});
    vecs.push_back('{0, 1, 70, 90, 32'h0123_4567, 1, 0, 1, 1, 8'hFF});
    vecs.push_back('{1, 1, 60, 100, 32'h10, 1, 0, 1, 0, 8'h01});
    vecs.push_back('{0, 1, 62, 101, 32'h20, 1, 1, 1, 0, 8'h03});
    vecs.push_back('{0, 0, 62, 5, 32'h30, 1, 1, 0, 0, 8'h01});
    vecs.push_back('{0, 0, 62, 6, 32'h40, 0, 0, 0, 0, 8'h01});
    vecs.push_back('{0, 1, 62, 50, 32'h50, 1, 1, 1, 0, 8'h03});
    vecs.push_back('{0, 1, 60, 0, 32'h60, 1, 0, 0, 0, 8'h02});
    vecs.push_back('{0, 1, 62, 70, 32'h70, 1, 1, 1, 0, 8'h02});

    i_reset = 1'b1; i_note_valid = 1'b0; i_note_on = 1'b0;
    i_note_num = '0; i_velocity = '0; i_tuning_code = '0;
    do_reset();

    chk("rst.ready", o_note_ready, 1);
    chk("rst.flag", o_voice_flag, 0);
    chk("rst.steal", o_steal, 0);
    chk("rst.idx", o_voice_index, 0);
    chk("rst.stat", o_voice_note_status, 0);
    chk("rst.tune", o_voice_tuning_code, 0);
    chk("rst.vel", o_voice_velocity, 0);
    chk("rst.mask", o_active_mask, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      run_event(vecs[i].on, vecs[i].note, vecs[i].vel, vecs[i].tune, o);
      model_event(vecs[i].on, vecs[i].note, vecs[i].vel, mf, mi, ms, mst);
      compare($sformatf("vec%0d", i), o, vecs[i].ef, vecs[i].ei,
              vecs[i].es, vecs[i].est, vecs[i].tune, vecs[i].vel,
              vecs[i].em);
    end

    // Reset in the middle of a scan aborts the command.
    i_note_on = 1'b1; i_note_num = 7'd66; i_velocity = 7'd9;
    i_tuning_code = 32'h99; i_note_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 i_note_valid = 1'b0;
    f1 = 0;
    repeat (3) begin
      @(posedge clk);
      #1 if (o_voice_flag) f1++;
    end
    i_reset = 1'b1;
    @(posedge clk);
    #1 i_reset = 1'b0;
    if (o_voice_flag) f1++;
    chk("midrst.noflag", f1, 0);
    chk("midrst.mask", o_active_mask, 0);
    chk("midrst.ready", o_note_ready, 1);
    chk("midrst.steal", o_steal, 0);
    model_reset();
    run_event(1, 7'd66, 7'd9, 32'h99, o);
    model_event(1, 66, 9, mf, mi, ms, mst);
    compare("midrst.next", o, 1, 0, 1, 0, 32'h99, 7'd9, 8'h01);

    // Two events back to back with valid held through the busy period.
    i_note_on = 1'b1; i_note_num = 7'd64; i_velocity = 7'd10;
    i_tuning_code = 32'hAAAA; i_note_valid = 1'b1;
    while (!o_note_ready) @(negedge clk);
    @(posedge clk);
    #1;
    i_note_num = 7'd65; i_velocity = 7'd11; i_tuning_code = 32'hBBBB;
    f1 = -1; f2 = -1; acc2 = -1; tune2 = '0; idx2 = '0;
    for (int e = 1; e <= 30; e++) begin
      @(negedge clk);
      if (acc2 < 0 && o_note_ready && i_note_valid) acc2 = e;
      @(posedge clk);
      #1;
      if (e == acc2) i_note_valid = 1'b0;
      if (o_voice_flag) begin
        if (f1 < 0) f1 = e;
        else begin
          f2 = e; tune2 = o_voice_tuning_code; idx2 = o_voice_index;
        end
      end
    end
    i_note_valid = 1'b0;
    model_event(1, 64, 10, mf, mi, ms, mst);
    model_event(1, 65, 11, mf, mi, ms, mst);
    chk("b2b.first_flag", f1, N);
    chk("b2b.accept2", acc2, N + 2);
    chk("b2b.spacing", f2 - f1, N + 2);
    chk("b2b.tune2", tune2, 32'hBBBB);
    chk("b2b.idx2", idx2, mi);
    chk("b2b.mask", o_active_mask, model_mask());
    last_tune = 32'hBBBB;
    last_idx = 8'(mi);

    // Randomized events against the reference model.
    for (int i = 0; i < 150; i++) begin
      ron = ($urandom_range(0, 2) != 0);
      rn = 7'(60 + $urandom_range(0, 11));
      rv = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      rt = $urandom;
      run_event(ron, rn, rv, rt, o);
      model_event(ron, rn, rv, mf, mi, ms, mst);
      compare($sformatf("rnd%0d", i), o, mf, mi, ms, mst, rt, rv,
              model_mask());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Polyphonic voice scheduler that sits between the MIDI/SPI note-event decoder and voice_controller. It accepts note-on/note-off events and assigns each note-on to a voice slot: a free voice if one exists, otherwise it steals the oldest voice. It then emits the single-cycle flagged command (voice index, tuning code, velocity, note status) that voice_controller consumes on its i_SPI_* inputs. It keeps a per-voice table of active bit, note number and age.

Parameters:
NUM_VOICES, 8, number of voice slots (2..256)
TUNING_W, 32, tuning-code width, passed through unchanged
AGE_W, 4, width of each per-voice saturating age counter

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_note_valid  in  1  note event present
o_note_ready  out  1  allocator can accept an event
i_note_on  in  1  1 = note-on, 0 = note-off
i_note_num  in  7  MIDI note number
i_velocity  in  7  MIDI velocity
i_tuning_code  in  TUNING_W  phase increment for the note
o_voice_flag  out  1  one-cycle command strobe to voice_controller
o_voice_index  out  8  target voice slot, zero-extended
o_voice_note_status  out  1  1 = start note, 0 = stop note
o_voice_tuning_code  out  TUNING_W  tuning code for the voice
o_voice_velocity  out  7  velocity for the voice
o_steal  out  1  one-cycle pulse, coincident with o_voice_flag, when an active voice was stolen
o_active_mask  out  NUM_VOICES  bit v = voice v is active

Behaviour:
- Reset values: o_note_ready=1, o_voice_flag=0, o_steal=0, o_voice_index=0, o_voice_note_status=0, o_voice_tuning_code=0, o_voice_velocity=0, o_active_mask=0. All table entries are cleared: active=0, note=0, age=0.
- Reset mid-operation aborts any scan with no command issued. The FSM returns to IDLE on the next cycle.
- FSM states:
  - IDLE: o_note_ready=1. On i_note_valid & o_note_ready at edge k, latch all event fields and go to SCAN.
  - SCAN: o_note_ready=0. Visit one voice per cycle, index 0..NUM_VOICES-1, over cycles k+1..k+NUM_VOICES. Record three things:
    - first voice with active=0;
    - first active voice whose note equals the latched note;
    - the active voice with the largest age, ties going to the lowest index.
    After the last voice, go to ISSUE.
  - ISSUE: lasts one cycle (k+NUM_VOICES+1). Drive any command, update the table, return to IDLE. o_note_ready=1 again at cycle k+NUM_VOICES+2.
- A note-on with i_velocity=0 is treated as a note-off.
- Note-on target selection, in priority order:
  1. Retrigger the matching voice. Its age resets to 0; other ages are unchanged.
  2. Otherwise, take the first free voice.
  3. Otherwise, steal the oldest voice and assert o_steal.
  Command: o_voice_flag=1, o_voice_note_status=1, tuning code and velocity from the latched event.
  Table update for cases 2 and 3: every active voice except the target increments its age, saturating at 2^AGE_W-1. The target gets active=1, its note stored, age=0.
- Note-off:
  - On a match: o_voice_flag=1, o_voice_note_status=0, o_voice_index=matched voice, tuning code and velocity from the latched event. Clear the voice's active bit and set its age to 0.
  - No match: no flag and no table change. Timing is identical to the matched case.
- o_voice_flag and o_steal are high for exactly one cycle per command. The other command outputs hold their last values between commands.
- o_active_mask is registered and reflects table state after the ISSUE-cycle update.
- Events presented while o_note_ready=0 are not accepted. The requester must hold i_note_valid until accepted.

Test Plan:
- Reset, then note-on note 60, vel 100, tuning 20000000 accepted at cycle k → o_voice_flag high only at k+9 (NUM_VOICES=8), index 0, status 1, tuning 20000000, vel 100; o_active_mask=8'h01.
- Note-ons for notes 60..67 → indices 0..7 in order, mask 8'hFF, no o_steal. Then note 70 → index 0 stolen (age 7), o_steal=1, tuning passed through.
- Notes 60, 62 on, then note-off 62 → flag at index 1, status 0, mask 8'h01. Then note-off 62 again → no flag; o_note_ready low for 9 cycles then high.
- Notes 60, 62 on, then note-on 60 vel 0 → treated as off: index 0, status 0. Then note-on 62 → retrigger index 1, no new allocation, mask unchanged.
- Assert i_reset in the middle of SCAN → no flag; next cycle mask=0, o_note_ready=1; the following note-on goes to index 0.
- Hold i_note_valid across a busy period with two back-to-back events → second accepted exactly at ready; two flags 10 cycles apart.
